// File: rtl/uart_program_loader.sv
// UART 8N1 receiver plus frame loader writing 32-bit words into instruction memory.
// Latency: rx_valid 1 clk after the stop-bit sample; wr_en 1 clk after the 4th byte of a word.
// Backpressure: none; the memory write port must accept a write on every wr_en pulse.
module uart_program_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int MAX_WORDS    = 64,
    parameter int TIMEOUT_CLKS = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        loading,
    output logic        done,
    output logic        err,
    output logic [7:0]  rx_byte,
    output logic        rx_valid
);
    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam int            TW        = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CLKS - 1);
    localparam logic [7:0]    MAX_N     = 8'(MAX_WORDS);
    localparam logic [7:0]    HDR       = 8'hA5;

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [1:0] {L_HDR, L_CNT, L_WORD, L_CSUM} ld_state_t;

    // ---------------- receive path ----------------
    logic          rx_meta, rx_s;
    rx_state_t     r_state, r_next;
    logic [CW-1:0] bit_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          shift_en, byte_ok, byte_bad, frame_err;

    // Idle-high synchroniser so reset never looks like a start bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_comb begin
        r_next   = r_state;
        shift_en = 1'b0;
        byte_ok  = 1'b0;
        byte_bad = 1'b0;
        case (r_state)
            R_IDLE:  if (!rx_s) r_next = R_START;
            R_START: if (bit_cnt == HALF_LAST) r_next = rx_s ? R_IDLE : R_DATA;
            R_DATA: begin
                if (bit_cnt == BIT_LAST) begin
                    shift_en = 1'b1;
                    if (bit_idx == 3'd7) r_next = R_STOP;
                end
            end
            R_STOP: begin
                if (bit_cnt == BIT_LAST) begin
                    r_next   = R_IDLE;
                    byte_ok  = rx_s;
                    byte_bad = !rx_s;
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= R_IDLE;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_byte   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            r_state <= r_next;
            if (r_next != r_state || r_state == R_IDLE || shift_en)
                bit_cnt <= '0;
            else
                bit_cnt <= bit_cnt + CW'(1);
            if (r_state == R_START)
                bit_idx <= '0;
            else if (shift_en)
                bit_idx <= bit_idx + 3'd1;
            if (shift_en)
                shreg <= {rx_s, shreg[7:1]};
            if (byte_ok)
                rx_byte <= shreg;
            rx_valid  <= byte_ok;
            frame_err <= byte_bad;
        end
    end

    // ---------------- frame loader ----------------
    ld_state_t     l_state, l_next;
    logic [7:0]    n_words, word_idx, csum;
    logic [1:0]    byte_k;
    logic [23:0]   word_lo;
    logic [TW-1:0] to_cnt;
    logic          start, fail, good, wr_fire, abort;

    // A late byte wins over a coincident timeout
    assign abort = frame_err || (loading && !rx_valid && to_cnt == TO_LAST);

    always_comb begin
        l_next  = l_state;
        start   = 1'b0;
        fail    = 1'b0;
        good    = 1'b0;
        wr_fire = 1'b0;
        case (l_state)
            L_HDR: begin
                if (rx_valid && rx_byte == HDR) begin
                    start  = 1'b1;
                    l_next = L_CNT;
                end
            end
            L_CNT: begin
                if (rx_valid) begin
                    if (rx_byte > MAX_N) begin
                        fail   = 1'b1;
                        l_next = L_HDR;
                    end else if (rx_byte == 8'd0) begin
                        l_next = L_CSUM;
                    end else begin
                        l_next = L_WORD;
                    end
                end
            end
            L_WORD: begin
                if (rx_valid && byte_k == 2'd3) begin
                    wr_fire = 1'b1;
                    if (word_idx + 8'd1 == n_words) l_next = L_CSUM;
                end
            end
            L_CSUM: begin
                if (rx_valid) begin
                    good   = (rx_byte == csum);
                    fail   = (rx_byte != csum);
                    l_next = L_HDR;
                end
            end
            default: l_next = L_HDR;
        endcase
        if (l_state != L_HDR && abort) begin
            fail    = 1'b1;
            good    = 1'b0;
            wr_fire = 1'b0;
            l_next  = L_HDR;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            l_state  <= L_HDR;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            loading  <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            n_words  <= '0;
            word_idx <= '0;
            csum     <= '0;
            byte_k   <= '0;
            word_lo  <= '0;
            to_cnt   <= '0;
        end else begin
            l_state <= l_next;
            wr_en   <= wr_fire;
            if (start) begin
                done     <= 1'b0;
                err      <= 1'b0;
                loading  <= 1'b1;
                csum     <= '0;
                word_idx <= '0;
                byte_k   <= '0;
            end
            if (fail) begin
                err     <= 1'b1;
                loading <= 1'b0;
            end
            if (good) begin
                done    <= 1'b1;
                loading <= 1'b0;
            end
            if (rx_valid && (l_state == L_CNT || l_state == L_WORD))
                csum <= csum ^ rx_byte;
            if (rx_valid && l_state == L_CNT)
                n_words <= rx_byte;
            if (rx_valid && l_state == L_WORD) begin
                byte_k <= byte_k + 2'd1;
                if (byte_k != 2'd3)
                    word_lo[{byte_k, 3'b000} +: 8] <= rx_byte;
            end
            if (wr_fire) begin
                wr_addr  <= {22'd0, word_idx, 2'b00};
                wr_data  <= {rx_byte, word_lo};
                word_idx <= word_idx + 8'd1;
            end
            // Holds the number of clks elapsed since the last received byte
            if (rx_valid)
                to_cnt <= TW'(1);
            else if (loading)
                to_cnt <= to_cnt + TW'(1);
            else
                to_cnt <= '0;
        end
    end
endmodule

// File: tb/tb_uart_program_loader.sv
// Bench for uart_program_loader: serialises frames onto rx and compares writes,
// received bytes and status flags against a frame-level expectation model.
module tb_uart_program_loader;
    localparam int CPB  = 4;
    localparam int MAXW = 64;
    localparam int TO   = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx  = 1'b1;
    logic        wr_en, loading, done, err, rx_valid;
    logic [31:0] wr_addr, wr_data;
    logic [7:0]  rx_byte;

    uart_program_loader #(
        .CLKS_PER_BIT(CPB),
        .MAX_WORDS   (MAXW),
        .TIMEOUT_CLKS(TO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rx      (rx),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .loading (loading),
        .done    (done),
        .err     (err),
        .rx_byte (rx_byte),
        .rx_valid(rx_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int last_rxv = 0;

    logic [31:0] got_addr[$], got_data[$], exp_addr[$], exp_data[$];
    logic [7:0]  got_rx[$], exp_rx[$];
    logic        exp_done = 1'b0;
    logic        exp_err  = 1'b0;
    logic [31:0] fw[64];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            if (wr_en) begin
                got_addr.push_back(wr_addr);
                got_data.push_back(wr_data);
            end
            if (rx_valid) begin
                got_rx.push_back(rx_byte);
                last_rxv = cyc;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_ok;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
        if (stop_ok) exp_rx.push_back(b);
    endtask

    task automatic glitch();
        @(negedge clk);
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
    endtask

    // Reference: a complete frame writes fw[0..n-1] at byte addresses 4*i,
    // and the status reflects whether the sent checksum matches XOR(N, data).
    task automatic send_frame(input int n, input bit force_cs, input logic [7:0] cs_val,
                              input logic [7:0] cs_xor);
        logic [7:0] cs, sent, nb;
        nb = 8'(n);
        cs = nb;
        for (int i = 0; i < n; i++)
            for (int k = 0; k < 4; k++) cs = cs ^ fw[i][8*k +: 8];
        sent = force_cs ? cs_val : (cs ^ cs_xor);
        send_byte(8'hA5, 1'b1);
        send_byte(nb, 1'b1);
        for (int i = 0; i < n; i++)
            for (int k = 0; k < 4; k++) send_byte(fw[i][8*k +: 8], 1'b1);
        send_byte(sent, 1'b1);
        for (int i = 0; i < n; i++) begin
            exp_addr.push_back(32'(4 * i));
            exp_data.push_back(fw[i]);
        end
        exp_done = (sent == cs);
        exp_err  = (sent != cs);
    endtask

    task automatic clear_q();
        got_addr.delete(); got_data.delete(); got_rx.delete();
        exp_addr.delete(); exp_data.delete(); exp_rx.delete();
    endtask

    task automatic compare_all(input string tag, input logic exp_loading);
        chk({tag, "/nwr"}, 32'(got_addr.size()), 32'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            chk($sformatf("%s/addr%0d", tag, i), got_addr[i], exp_addr[i]);
            chk($sformatf("%s/data%0d", tag, i), got_data[i], exp_data[i]);
        end
        chk({tag, "/nrx"}, 32'(got_rx.size()), 32'(exp_rx.size()));
        for (int i = 0; i < exp_rx.size() && i < got_rx.size(); i++)
            chk($sformatf("%s/rx%0d", tag, i), 32'(got_rx[i]), 32'(exp_rx[i]));
        chk({tag, "/done"}, 32'(done), 32'(exp_done));
        chk({tag, "/err"}, 32'(err), 32'(exp_err));
        chk({tag, "/loading"}, 32'(loading), 32'(exp_loading));
        clear_q();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "/wr_en"}, 32'(wr_en), 32'd0);
        chk({tag, "/wr_addr"}, wr_addr, 32'd0);
        chk({tag, "/wr_data"}, wr_data, 32'd0);
        chk({tag, "/loading"}, 32'(loading), 32'd0);
        chk({tag, "/done"}, 32'(done), 32'd0);
        chk({tag, "/err"}, 32'(err), 32'd0);
        chk({tag, "/rx_byte"}, 32'(rx_byte), 32'd0);
        chk({tag, "/rx_valid"}, 32'(rx_valid), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        logic [7:0] db[5];
        int         target, n;
        bit         bad;

        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // 1: single-word frame with good checksum
        fw[0] = 32'h0050_0013;
        send_frame(1, 1'b0, 8'h00, 8'h00);
        compare_all("c1", 1'b0);

        // 2: two words, wrong checksum 0x00
        fw[0] = 32'h0050_0093;
        fw[1] = 32'h00A0_0113;
        send_frame(2, 1'b1, 8'h00, 8'h00);
        compare_all("c2", 1'b0);

        // 3: idle bytes and a glitch; status untouched
        send_byte(8'h00, 1'b1);
        glitch();
        send_byte(8'hFF, 1'b1);
        send_byte(8'h3C, 1'b1);
        compare_all("c3", 1'b0);

        // 4: framing error inside a word, then a good frame
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h13, 1'b1);
        send_byte(8'h00, 1'b0);
        exp_done = 1'b0;
        exp_err  = 1'b1;
        compare_all("c4a", 1'b0);
        fw[0] = $urandom;
        send_frame(1, 1'b0, 8'h00, 8'h00);
        compare_all("c4b", 1'b0);

        // 5a: oversize count
        send_byte(8'hA5, 1'b1);
        send_byte(8'h41, 1'b1);
        exp_done = 1'b0;
        exp_err  = 1'b1;
        compare_all("c5a", 1'b0);

        // 5b: truncated frame then silence -> timeout
        for (int i = 0; i < 5; i++) db[i] = 8'($urandom);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        for (int i = 0; i < 5; i++) send_byte(db[i], 1'b1);
        chk("c5b/loading_mid", 32'(loading), 32'd1);
        chk("c5b/err_mid", 32'(err), 32'd0);
        target = last_rxv + TO - 1;
        while (cyc < target) @(negedge clk);
        chk("c5b/err_before_to", 32'(err), 32'd0);
        @(negedge clk);
        chk("c5b/err_at_to", 32'(err), 32'd1);
        exp_addr.push_back(32'd0);
        exp_data.push_back({db[3], db[2], db[1], db[0]});
        exp_err = 1'b1;
        compare_all("c5b", 1'b0);

        // 6: reset mid-word, then reload from address 0
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h13, 1'b1);
        send_byte(8'h00, 1'b1);
        chk("c6/loading_pre", 32'(loading), 32'd1);
        rst = 1'b0;
        #1;
        check_zero("c6rst");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        clear_q();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        repeat (2) @(negedge clk);
        fw[0] = 32'h0050_0013;
        send_frame(1, 1'b0, 8'h00, 8'h00);
        compare_all("c6", 1'b0);

        // Boundary: full-depth frame
        for (int i = 0; i < MAXW; i++) fw[i] = $urandom;
        send_frame(MAXW, 1'b0, 8'h00, 8'h00);
        compare_all("full", 1'b0);

        // Randomised frames with idle noise, N=0 allowed, header byte inside data
        for (int r = 0; r < 6; r++) begin
            repeat ($urandom_range(0, 2)) begin
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h5A;
                send_byte(b, 1'b1);
            end
            n = $urandom_range(0, 6);
            for (int i = 0; i < 8; i++) fw[i] = $urandom;
            if (r == 1) begin
                n = 3;
                fw[0][15:8] = 8'hA5;
            end
            bad = ($urandom_range(0, 2) == 0);
            send_frame(n, 1'b0, 8'h00, bad ? 8'($urandom_range(1, 255)) : 8'h00);
            compare_all($sformatf("rnd%0d", r), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
